// File: rtl/lr3_disp_pkg.sv
// ---------------------------------------------------------------------------
// lr3_disp_pkg
// Shared constants for the 7-segment display scanner:
//   - SEG_A..SEG_G : bit positions of each segment in a 7-bit segment word
//   - SEG_CODE     : active-high gfedcba patterns for hex digits 0..F
//   - hex_to_seg() : nibble -> active-high segment word
// ---------------------------------------------------------------------------
package lr3_disp_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Glyphs: 0 1 2 3 4 5 6 7 8 9 A b C d E F
  localparam logic [6:0] SEG_CODE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return SEG_CODE[nib];
  endfunction

endpackage

// File: rtl/lr3_hex7seg.sv
// ---------------------------------------------------------------------------
// lr3_hex7seg
// Combinational hex nibble to 7-segment decoder, active-high outputs.
// Ports:
//   nib  in  4  hex digit value
//   seg  out 7  segment pattern, seg[SEG_A]=a ... seg[SEG_G]=g
// ---------------------------------------------------------------------------
module lr3_hex7seg
  import lr3_disp_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  logic [6:0] code;

  assign code = hex_to_seg(nib);

  // Named taps keep the a..g pin mapping explicit at the module boundary.
  assign seg[SEG_A] = code[SEG_A];
  assign seg[SEG_B] = code[SEG_B];
  assign seg[SEG_C] = code[SEG_C];
  assign seg[SEG_D] = code[SEG_D];
  assign seg[SEG_E] = code[SEG_E];
  assign seg[SEG_F] = code[SEG_F];
  assign seg[SEG_G] = code[SEG_G];

endmodule

// File: rtl/lr3_disp_scan.sv
// ---------------------------------------------------------------------------
// lr3_disp_scan
// Multiplexed 7-segment display scanner. Each DISP_CE strobe advances the
// active digit; new display data is staged by LOAD and committed only when
// the digit index wraps, so a frame never mixes old and new data.
// Ports:
//   CLK, RST_N   clock, asynchronous active-low reset
//   DISP_CE      one-cycle scan-step strobe
//   DATA_IN      4*N_DIGITS hex nibbles, digit i = DATA_IN[4i+3:4i]
//   DP_IN        decimal point per digit
//   EN_IN        per-digit enable mask
//   LOAD         capture DATA_IN/DP_IN/EN_IN into staging
//   LOAD_ACK     one-cycle pulse when staged data is committed
//   PENDING      staging holds uncommitted data
//   FRAME_DONE   one-cycle pulse on digit-index wrap
//   AN, SEG, DP  anodes, segments (SEG[0]=a..SEG[6]=g), decimal point
// All outputs are registered. Polarity inversion happens only at the
// output registers; everything internal is active-high.
// ---------------------------------------------------------------------------
module lr3_disp_scan
  import lr3_disp_pkg::*;
#(
  parameter int N_DIGITS    = 8,
  parameter int BLANK_CYC   = 2,
  parameter bit LZB         = 1'b1,
  parameter bit AN_ACT_LOW  = 1'b1,
  parameter bit SEG_ACT_LOW = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  DISP_CE,
  input  logic [4*N_DIGITS-1:0] DATA_IN,
  input  logic [N_DIGITS-1:0]   DP_IN,
  input  logic [N_DIGITS-1:0]   EN_IN,
  input  logic                  LOAD,
  output logic                  LOAD_ACK,
  output logic                  PENDING,
  output logic                  FRAME_DONE,
  output logic [N_DIGITS-1:0]   AN,
  output logic [6:0]            SEG,
  output logic                  DP
);

  localparam int                IW      = $clog2(N_DIGITS);
  localparam logic [IW-1:0]     LAST    = IW'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] AN_OFF  = {N_DIGITS{AN_ACT_LOW}};
  localparam logic [6:0]        SEG_OFF = {7{SEG_ACT_LOW}};

  // Current state
  logic [IW-1:0]         idx;
  logic [7:0]            blank_cnt;
  logic [4*N_DIGITS-1:0] act_data, stage_data;
  logic [N_DIGITS-1:0]   act_dp, stage_dp;
  logic [N_DIGITS-1:0]   act_en, stage_en;

  // Next state; the output registers are computed from these so that
  // SEG/DP for the newly selected digit appear one cycle after DISP_CE.
  logic                  wrap;
  logic [IW-1:0]         idx_n;
  logic [7:0]            blank_n;
  logic [4*N_DIGITS-1:0] act_data_n;
  logic [N_DIGITS-1:0]   act_dp_n;
  logic [N_DIGITS-1:0]   act_en_n;

  logic [3:0]            nib_n [N_DIGITS];
  logic [N_DIGITS-1:0]   tail_zero;
  logic [3:0]            cur_nib;
  logic [6:0]            cur_seg;
  logic                  show;
  logic [N_DIGITS-1:0]   an_hi;
  logic [6:0]            seg_hi;
  logic                  dp_hi;

  // NOTE: every variable assigned in an always_comb gets a default at the
  // top of the block, so no path can leave it unassigned and infer a latch.
  always_comb begin
    wrap       = DISP_CE && (idx == LAST);
    idx_n      = idx;
    act_data_n = act_data;
    act_dp_n   = act_dp;
    act_en_n   = act_en;
    blank_n    = (blank_cnt != 8'd0) ? blank_cnt - 8'd1 : 8'd0;

    if (DISP_CE) begin
      idx_n   = wrap ? '0 : idx + 1'b1;
      blank_n = 8'(BLANK_CYC);
    end

    // A LOAD coinciding with the wrap bypasses staging so the new frame
    // starts with the freshest data.
    if (wrap && LOAD) begin
      act_data_n = DATA_IN;
      act_dp_n   = DP_IN;
      act_en_n   = EN_IN;
    end else if (wrap && PENDING) begin
      act_data_n = stage_data;
      act_dp_n   = stage_dp;
      act_en_n   = stage_en;
    end
  end

  // tail_zero[i]: every nibble and DP bit from digit i up to the top digit
  // is zero, i.e. digit i is a leading zero.
  always_comb begin
    logic z;
    z         = 1'b1;
    tail_zero = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      nib_n[i] = act_data_n[4*i +: 4];
    end
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      z            = z && (nib_n[i] == 4'd0) && !act_dp_n[i];
      tail_zero[i] = z;
    end
  end

  assign cur_nib = nib_n[idx_n];

  lr3_hex7seg u_hex7seg (
    .nib (cur_nib),
    .seg (cur_seg)
  );

  // A suppressed digit still consumes its scan slot but lights nothing.
  always_comb begin
    show   = act_en_n[idx_n] && !(LZB && (idx_n != '0) && tail_zero[idx_n]);
    an_hi  = '0;
    seg_hi = show ? cur_seg : 7'd0;
    dp_hi  = show && act_dp_n[idx_n];
    if (show && (blank_n == 8'd0)) begin
      an_hi[idx_n] = 1'b1;
    end
  end

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples pre-edge values regardless of statement order.
  // NOTE: the data registers here are plain flops, not a RAM, so they take
  // the asynchronous reset like the rest of the state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      idx        <= '0;
      blank_cnt  <= 8'd0;
      act_data   <= '0;
      act_dp     <= '0;
      act_en     <= '0;
      stage_data <= '0;
      stage_dp   <= '0;
      stage_en   <= '0;
      PENDING    <= 1'b0;
      LOAD_ACK   <= 1'b0;
      FRAME_DONE <= 1'b0;
      AN         <= AN_OFF;
      SEG        <= SEG_OFF;
      DP         <= SEG_ACT_LOW;
    end else begin
      idx       <= idx_n;
      blank_cnt <= blank_n;
      act_data  <= act_data_n;
      act_dp    <= act_dp_n;
      act_en    <= act_en_n;

      if (LOAD) begin
        stage_data <= DATA_IN;
        stage_dp   <= DP_IN;
        stage_en   <= EN_IN;
      end

      // Wrap always empties staging: it either commits or bypasses.
      if (wrap) begin
        PENDING <= 1'b0;
      end else if (LOAD) begin
        PENDING <= 1'b1;
      end

      LOAD_ACK   <= wrap && (LOAD || PENDING);
      FRAME_DONE <= wrap;
      AN         <= an_hi ^ AN_OFF;
      SEG        <= seg_hi ^ SEG_OFF;
      DP         <= dp_hi ^ SEG_ACT_LOW;
    end
  end

endmodule
